dmem_mmio: RTL and testbench

//  Data-memory stage downstream of the single-cycle RV32 core.
//  - Consumes MemWrite, ALUResult (address), WriteData and Instr[14:12] (funct3).
//  - Returns ReadData in the same cycle: load-extended from DMEM, or taken from a small MMIO block.
//  - MMIO block: 8-bit TX FIFO with valid/ready drain, plus 32-bit mtime/mtimecmp timer.

---
 rtl/dmem_mmio.sv | 160 ++++++++++++++++
 tb/tb_dmem_mmio.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// Data-memory stage: byte-enabled DMEM plus MMIO block (TX byte FIFO, mtime/mtimecmp timer).
// Latency: loads/MMIO reads combinational (0 cycles); stores, pushes, timer writes visible next cycle.
// Backpressure: TX FIFO drains on tx_valid && tx_ready; a push into a full FIFO without a same-cycle pop is dropped and sets ovf.
module dmem_mmio #(
  parameter int unsigned DMEM_WORDS = 256,
  parameter int unsigned TX_DEPTH   = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        misalign,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int unsigned DW = $clog2(DMEM_WORDS);
  localparam int unsigned AW = $clog2(TX_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [31:0]   DMEM_BYTES = 32'(DMEM_WORDS * 4);
  localparam logic [PW-1:0] DEPTH_P    = PW'(TX_DEPTH);

  logic [31:0]   dmem_q [DMEM_WORDS];
  logic [7:0]    fifo_q [TX_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count;
  logic [2:0]    cnt3;
  logic          ovf_q, ovf_d;
  logic [31:0]   mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic          timer_irq_q;

  logic        is_dmem, is_mmio, full, empty, pop, push, accept, drop;
  logic        st_ok, dm_we, mm_we;
  logic [1:0]  off, lane;
  logic [3:0]  be;
  logic [31:0] wd_rep, word_rd, shifted, status;

  assign lane    = ALUResult[1:0];
  assign off     = ALUResult[3:2];
  assign is_dmem = ALUResult < DMEM_BYTES;
  assign is_mmio = ALUResult[31:4] == MMIO_BASE[31:4];

  // Halfword (signed or unsigned) on an odd byte, or word off a 4-byte boundary.
  assign misalign = ((funct3[1:0] == 2'b01) && lane[0]) ||
                    ((funct3 == 3'b010) && (lane != 2'b00));

  assign count    = wptr_q - rptr_q;
  assign cnt3     = 3'(count);
  assign full     = count == DEPTH_P;
  assign empty    = count == '0;
  assign tx_valid = !empty;
  assign tx_data  = fifo_q[rptr_q[AW-1:0]];
  assign pop      = tx_valid && tx_ready;

  assign st_ok  = MemWrite && !misalign;
  assign dm_we  = st_ok && is_dmem && (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
  assign mm_we  = st_ok && is_mmio && (funct3 == 3'b010);
  assign push   = mm_we && (off == 2'd0);
  // A pop in the same cycle frees the slot, so a full FIFO can still take the byte.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  assign status    = {25'b0, cnt3, 1'b0, ovf_q, empty, full};
  assign timer_irq = timer_irq_q;

  // Store lane enables and data replicated across the lanes.
  always_comb begin
    be     = 4'b0000;
    wd_rep = WriteData;
    case (funct3)
      3'b000: begin
        be     = 4'b0001 << lane;
        wd_rep = {4{WriteData[7:0]}};
      end
      3'b001: begin
        be     = lane[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{WriteData[15:0]}};
      end
      3'b010: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Load path: select source word, then extract and extend the addressed lane(s).
  always_comb begin
    word_rd = 32'h0;
    if (is_dmem) begin
      word_rd = dmem_q[ALUResult[DW+1:2]];
    end else if (is_mmio) begin
      case (off)
        2'd1:    word_rd = status;
        2'd2:    word_rd = mtime_q;
        2'd3:    word_rd = mtimecmp_q;
        default: word_rd = 32'h0;
      endcase
    end
    shifted = word_rd >> {lane, 3'b000};
    case (funct3)
      3'b000:  ReadData = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ReadData = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  ReadData = word_rd;
      3'b100:  ReadData = {24'h0, shifted[7:0]};
      3'b101:  ReadData = {16'h0, shifted[15:0]};
      default: ReadData = 32'h0;
    endcase
  end

  // Next-state for FIFO pointers, overflow flag and timer registers.
  always_comb begin
    rptr_d     = rptr_q + PW'(pop);
    wptr_d     = wptr_q + PW'(accept);
    ovf_d      = ovf_q;
    mtime_d    = mtime_q + 32'd1;
    mtimecmp_d = mtimecmp_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (mm_we && off == 2'd1 && WriteData[2]) begin
      ovf_d = 1'b0;
    end
    if (mm_we && off == 2'd2) mtime_d = WriteData;
    if (mm_we && off == 2'd3) mtimecmp_d = WriteData;
  end

  // Control state with synchronous reset; irq follows the next-state compare so it has no lag.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      ovf_q       <= 1'b0;
      mtime_q     <= 32'h0;
      mtimecmp_q  <= 32'hFFFF_FFFF;
      timer_irq_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ovf_q       <= ovf_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      timer_irq_q <= mtime_d >= mtimecmp_d;
    end
  end

  // FIFO storage: not reset; a push in the reset cycle is never written.
  always_ff @(posedge clk) begin
    if (!n_rst && accept) fifo_q[wptr_q[AW-1:0]] <= WriteData[7:0];
  end

  // DMEM array: not reset, byte-lane writes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (dm_we && be[i]) dmem_q[ALUResult[DW+1:2]][8*i +: 8] <= wd_rep[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: directed scenarios then randomized traffic vs a byte-level model.
// Driver pushes expected load/misalign results and TX bytes; monitor pops on each DUT cycle/handshake.
// Model is per-byte memory plus a byte queue and plain timer counters.
module tb_dmem_mmio;
  localparam int DEPTH = 4;
  localparam logic [31:0] TXD = 32'hFFFF_0000, STS = 32'hFFFF_0004,
                          MTM = 32'hFFFF_0008, CMP = 32'hFFFF_000C, UNM = 32'h0000_4000;

  logic        clk = 1'b0, n_rst = 1'b1, MemWrite = 1'b0, tx_ready = 1'b0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] ALUResult = 32'h0, WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        misalign, tx_valid, timer_irq;
  logic [7:0]  tx_data;

  dmem_mmio dut (
    .clk(clk), .n_rst(n_rst), .MemWrite(MemWrite), .funct3(funct3),
    .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData),
    .misalign(misalign), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    bit          chk;
    logic [31:0] rd;
    bit          mis;
  } exp_t;

  exp_t        op_q[$];
  logic [7:0]  tx_q[$];
  bit          op_vld = 1'b0, mon_en = 1'b0;
  int          checks = 0, errors = 0, op_id = 0;

  logic [7:0]  dm [0:1023];
  int          tx_cnt = 0;
  bit          ovf_m = 1'b0, irq_m = 1'b0;
  logic [31:0] mtime_m = 32'h0, cmp_m = 32'hFFFF_FFFF;

  task automatic check(string nm, int id, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s op=%0d got=%h exp=%h", nm, id, act, exp);
    end
  endtask

  function automatic bit is_mis(logic [2:0] f3, logic [31:0] a);
    return ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic bit in_mmio(logic [31:0] a);
    return a[31:4] == 28'hFFFF000;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] a, logic [2:0] f3);
    logic [31:0] w, s;
    int base;
    w = 32'h0;
    if (a < 32'd1024) begin
      base = int'(a) & ~3;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = dm[base + k];
    end else if (in_mmio(a)) begin
      case (a[3:2])
        2'd1: w = {25'b0, 3'(tx_cnt), 1'b0, ovf_m, tx_cnt == 0, tx_cnt == DEPTH};
        2'd2: w = mtime_m;
        2'd3: w = cmp_m;
        default: w = 32'h0;
      endcase
    end
    s = w >> (8 * int'(a[1:0]));
    case (f3)
      3'd0: return {{24{s[7]}}, s[7:0]};
      3'd1: return {{16{s[15]}}, s[15:0]};
      3'd2: return w;
      3'd4: return {24'h0, s[7:0]};
      3'd5: return {16'h0, s[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_step(bit we, logic [2:0] f3, logic [31:0] a,
                                     logic [31:0] wd, bit rdy, bit mis);
    logic [31:0] nt;
    int nb;
    nt = mtime_m + 32'd1;
    if (tx_cnt > 0 && rdy) tx_cnt--;
    if (we && !mis) begin
      if (a < 32'd1024 && f3 <= 3'd2) begin
        nb = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int k = 0; k < nb; k++) dm[int'(a) + k] = wd[8*k +: 8];
      end else if (in_mmio(a) && f3 == 3'd2) begin
        case (a[3:2])
          2'd0: if (tx_cnt < DEPTH) begin
                  tx_q.push_back(wd[7:0]);
                  tx_cnt++;
                end else ovf_m = 1'b1;
          2'd1: if (wd[2]) ovf_m = 1'b0;
          2'd2: nt = wd;
          default: cmp_m = wd;
        endcase
      end
    end
    mtime_m = nt;
    irq_m   = mtime_m >= cmp_m;
  endfunction

  task automatic op(bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd, bit rdy,
                    bit lit = 1'b0, logic [31:0] lv = 32'h0);
    exp_t e;
    bit mis;
    MemWrite = we; funct3 = f3; ALUResult = a; WriteData = wd; tx_ready = rdy;
    mis   = is_mis(f3, a);
    e.id  = op_id++;
    e.mis = mis;
    e.chk = !we && !mis;
    e.rd  = lit ? lv : model_load(a, f3);
    op_q.push_back(e);
    op_vld = 1'b1;
    @(posedge clk);
    model_step(we, f3, a, wd, rdy, mis);
    #1;
    op_vld = 1'b0;
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) op(1'b0, 3'd2, UNM, 32'h0, rdy);
  endtask

  task automatic do_reset(bit push_in_rst);
    n_rst = 1'b1; MemWrite = push_in_rst; funct3 = 3'd2; ALUResult = TXD; WriteData = 32'hEE;
    op_vld = 1'b0;
    @(posedge clk);
    tx_q.delete(); tx_cnt = 0; ovf_m = 1'b0; mtime_m = 32'h0; cmp_m = 32'hFFFF_FFFF; irq_m = 1'b0;
    #1;
    n_rst = 1'b0; MemWrite = 1'b0;
  endtask

  // Monitor: one op result per driven cycle, plus irq/tx_valid every cycle and tx bytes on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (op_vld) begin
          if (op_q.size() == 0) begin
            checks++; errors++; $display("FAIL opq_underflow");
          end else begin
            e = op_q.pop_front();
            check("misalign", e.id, {31'b0, misalign}, {31'b0, e.mis});
            if (e.chk) check("rdata", e.id, ReadData, e.rd);
          end
        end
        check("timer_irq", op_id, {31'b0, timer_irq}, {31'b0, irq_m});
        check("tx_valid", op_id, {31'b0, tx_valid}, {31'b0, tx_cnt != 0});
        if (tx_valid === 1'b1 && tx_ready) begin
          if (tx_q.size() == 0) begin
            checks++; errors++; $display("FAIL tx_underflow got=%h", tx_data);
          end else begin
            check("tx_data", op_id, {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, wd;
    logic [2:0]  f3;
    bit          we, rdy;
    int          r, rg;

    do_reset(1'b0);
    mon_en = 1'b1;
    op(1'b0, 3'd2, STS, 32'h0, 1'b0, 1'b1, 32'h0000_0002);
    op(1'b0, 3'd2, MTM, 32'h0, 1'b0, 1'b1, 32'h0000_0001);

    for (int i = 0; i < 256; i++) op(1'b1, 3'd2, 32'(i * 4), $urandom, 1'b0);

    // Sign/zero extension of byte and halfword lanes.
    op(1'b1, 3'd2, 32'h10, 32'h8000_00F1, 1'b0);
    op(1'b0, 3'd0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFF1);
    op(1'b0, 3'd4, 32'h13, 32'h0, 1'b0, 1'b1, 32'h0000_0080);
    op(1'b0, 3'd1, 32'h12, 32'h0, 1'b0, 1'b1, 32'hFFFF_8000);
    op(1'b0, 3'd5, 32'h12, 32'h0, 1'b0, 1'b1, 32'h0000_8000);
    // Byte and halfword merge into one word.
    op(1'b1, 3'd2, 32'h20, 32'h0, 1'b0);
    op(1'b1, 3'd0, 32'h21, 32'h1234_56AB, 1'b0);
    op(1'b1, 3'd1, 32'h22, 32'h0000_BEEF, 1'b0);
    op(1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 1'b1, 32'hBEEF_AB00);
    // Misaligned store suppressed, misaligned halfword flagged.
    op(1'b1, 3'd2, 32'h20, 32'h1111_1111, 1'b0);
    op(1'b1, 3'd2, 32'h22, 32'hDEAD_BEEF, 1'b0);
    op(1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 1'b1, 32'h1111_1111);
    op(1'b0, 3'd1, 32'h21, 32'h0, 1'b0);
    // TX FIFO fill, overflow, then drain.
    for (int i = 1; i <= 5; i++) op(1'b1, 3'd2, TXD, 32'(i), 1'b0);
    op(1'b0, 3'd2, STS, 32'h0, 1'b0, 1'b1, 32'h0000_0045);
    idle(6, 1'b1);
    op(1'b1, 3'd2, STS, 32'h4, 1'b0);
    op(1'b0, 3'd2, STS, 32'h0, 1'b0, 1'b1, 32'h0000_0002);
    // Timer compare timing, then raising mtimecmp drops irq.
    op(1'b1, 3'd2, CMP, 32'd10, 1'b0);
    op(1'b1, 3'd2, MTM, 32'd5, 1'b0);
    idle(7, 1'b0);
    op(1'b1, 3'd2, CMP, 32'd100, 1'b0);
    idle(2, 1'b0);
    // Mtime wrap with irq asserted.
    op(1'b1, 3'd2, CMP, 32'hFFFF_FFFD, 1'b0);
    op(1'b1, 3'd2, MTM, 32'hFFFF_FFFB, 1'b0);
    idle(6, 1'b0);
    // Reset mid-transfer with a push in the reset cycle.
    for (int i = 0; i < 3; i++) op(1'b1, 3'd2, TXD, 32'hA0 + 32'(i), 1'b0);
    do_reset(1'b1);
    op(1'b0, 3'd2, STS, 32'h0, 1'b0, 1'b1, 32'h0000_0002);
    op(1'b0, 3'd2, MTM, 32'h0, 1'b0, 1'b1, 32'h0000_0001);

    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom % 100);
      if (r < 2) begin
        do_reset(1'($urandom % 2));
      end else begin
        rg  = int'($urandom % 10);
        f3  = 3'($urandom % 8);
        we  = 1'($urandom % 2);
        wd  = $urandom;
        rdy = 1'($urandom % 2);
        if (rg < 5) begin
          a = $urandom % 1024;
        end else if (rg < 9) begin
          a = TXD | 32'($urandom % 16);
          if ($urandom % 10 < 7) begin
            a[1:0] = 2'b00;
            f3 = 3'd2;
          end
          if (a[3:2] == 2'd2 || a[3:2] == 2'd3)
            wd = ($urandom % 8 == 0) ? 32'hFFFF_FFF0 + ($urandom % 16) : mtime_m + ($urandom % 30);
        end else begin
          a = 32'h0001_0000 + ($urandom % 32'h10000);
        end
        if (we && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
        op(we, f3, a, wd, rdy);
      end
    end
    idle(2, 1'b1);
    check("opq_drained", op_id, 32'(op_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
